// File: rtl/cond_unit.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field once per
// instruction in decode, gates the FSM write requests and counts executed/squashed instructions.
module cond_unit #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         Cond,
  input  logic [3:0]         ALUFlags,
  input  logic [1:0]         FlagW,
  input  logic               IRWrite,
  input  logic               RegW,
  input  logic               MemW,
  input  logic               NextPC,
  input  logic               Branch,
  input  logic               cnt_clr,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic [3:0]         Flags,
  output logic               CondExQ,
  output logic [COUNT_W-1:0] exec_count,
  output logic [COUNT_W-1:0] squash_count
);

  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondCs = 4'h2,
    CondCc = 4'h3,
    CondMi = 4'h4,
    CondPl = 4'h5,
    CondVs = 4'h6,
    CondVc = 4'h7,
    CondHi = 4'h8,
    CondLs = 4'h9,
    CondGe = 4'hA,
    CondLt = 4'hB,
    CondGt = 4'hC,
    CondLe = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

  localparam logic [COUNT_W-1:0] CntMax = '1;
  localparam logic [COUNT_W-1:0] CntOne = COUNT_W'(1);

  logic [3:0]         flags_q, flags_d;
  logic               condex_q, condex_d;
  logic               decode_q, decode_d;
  logic [COUNT_W-1:0] exec_q, exec_d;
  logic [COUNT_W-1:0] squash_q, squash_d;

  logic flagN, flagZ, flagC, flagV;
  logic condPass;

  assign flagN = flags_q[3];
  assign flagZ = flags_q[2];
  assign flagC = flags_q[1];
  assign flagV = flags_q[0];

  // Condition evaluation always uses the registered flags, never the live ALU flags.
  always_comb begin
    condPass = 1'b0;
    case (cond_e'(Cond))
      CondEq:  condPass = flagZ;
      CondNe:  condPass = ~flagZ;
      CondCs:  condPass = flagC;
      CondCc:  condPass = ~flagC;
      CondMi:  condPass = flagN;
      CondPl:  condPass = ~flagN;
      CondVs:  condPass = flagV;
      CondVc:  condPass = ~flagV;
      CondHi:  condPass = flagC & ~flagZ;
      CondLs:  condPass = ~flagC | flagZ;
      CondGe:  condPass = (flagN == flagV);
      CondLt:  condPass = (flagN != flagV);
      CondGt:  condPass = ~flagZ & (flagN == flagV);
      CondLe:  condPass = flagZ | (flagN != flagV);
      CondAl:  condPass = 1'b1;
      default: condPass = 1'b0;
    endcase
  end

  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    decode_d = IRWrite;
    exec_d   = exec_q;
    squash_d = squash_q;

    if (FlagW[1] && condex_q) flags_d[3:2] = ALUFlags[3:2];
    if (FlagW[0] && condex_q) flags_d[1:0] = ALUFlags[1:0];

    // A fresh fetch clears the pass bit, but an evaluation in the same edge overrides it.
    if (IRWrite)  condex_d = 1'b0;
    if (decode_q) condex_d = condPass;

    if (cnt_clr) begin
      exec_d   = '0;
      squash_d = '0;
    end else if (decode_q) begin
      if (condPass) begin
        if (exec_q != CntMax) exec_d = exec_q + CntOne;
      end else begin
        if (squash_q != CntMax) squash_d = squash_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q  <= '0;
      condex_q <= 1'b0;
      decode_q <= 1'b0;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      condex_q <= condex_d;
      decode_q <= decode_d;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

  assign PCWrite      = NextPC | (Branch & condex_q);
  assign RegWrite     = RegW & condex_q;
  assign MemWrite     = MemW & condex_q;
  assign Flags        = flags_q;
  assign CondExQ      = condex_q;
  assign exec_count   = exec_q;
  assign squash_count = squash_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed steps plus random cycles compared
// against a behavioural model of the conditional-execution rules.
module tb_cond_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    Cond, ALUFlags;
  logic [1:0]    FlagW;
  logic          IRWrite, RegW, MemW, NextPC, Branch, cnt_clr;
  logic          PCWrite, RegWrite, MemWrite, CondExQ;
  logic [3:0]    Flags;
  logic [CW-1:0] exec_count, squash_count;

  int nChecks = 0;
  int nFails  = 0;

  logic [3:0] mFlags;
  logic       mCondEx, mDecode;
  int         mExec, mSquash;

  cond_unit #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .IRWrite(IRWrite), .RegW(RegW), .MemW(MemW), .NextPC(NextPC), .Branch(Branch),
    .cnt_clr(cnt_clr), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondExQ(CondExQ), .exec_count(exec_count), .squash_count(squash_count)
  );

  always #5 clk = ~clk;

  // Architectural view: odd codes are the complement of the even code below them.
  function automatic logic refEval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".Flags"},    32'(Flags),        32'(mFlags));
    chk({tag, ".CondExQ"},  32'(CondExQ),      32'(mCondEx));
    chk({tag, ".exec"},     32'(exec_count),   32'(mExec));
    chk({tag, ".squash"},   32'(squash_count), 32'(mSquash));
    chk({tag, ".PCWrite"},  32'(PCWrite),      32'(NextPC | (Branch & mCondEx)));
    chk({tag, ".RegWrite"}, 32'(RegWrite),     32'(RegW & mCondEx));
    chk({tag, ".MemWrite"}, 32'(MemWrite),     32'(MemW & mCondEx));
  endtask

  task automatic modelReset();
    mFlags = 4'h0; mCondEx = 1'b0; mDecode = 1'b0; mExec = 0; mSquash = 0;
  endtask

  // One clock: compute the model's next state from pre-edge inputs, clock, commit.
  task automatic applyStimulus();
    logic [3:0] nF;
    logic       nC, ev;
    int         nE, nS;
    ev = refEval(Cond, mFlags);
    nF = mFlags;
    if (FlagW[1] && mCondEx) nF[3:2] = ALUFlags[3:2];
    if (FlagW[0] && mCondEx) nF[1:0] = ALUFlags[1:0];
    nC = mDecode ? ev : (IRWrite ? 1'b0 : mCondEx);
    nE = mExec; nS = mSquash;
    if (cnt_clr) begin
      nE = 0; nS = 0;
    end else if (mDecode) begin
      if (ev) nE = (mExec < CMAX) ? mExec + 1 : CMAX;
      else    nS = (mSquash < CMAX) ? mSquash + 1 : CMAX;
    end
    @(posedge clk);
    #1;
    if (!reset) modelReset();
    else begin
      mFlags = nF; mCondEx = nC; mDecode = IRWrite; mExec = nE; mSquash = nS;
    end
  endtask

  task automatic idleInputs();
    IRWrite = 0; RegW = 0; MemW = 0; NextPC = 0; Branch = 0;
    FlagW = 2'b00; ALUFlags = 4'h0; cnt_clr = 0;
  endtask

  // Fetch then decode with the given condition; leaves inputs idle in execute.
  task automatic fetchDecode(input logic [3:0] c);
    idleInputs();
    IRWrite = 1; NextPC = 1;
    applyStimulus();
    idleInputs();
    Cond = c;
    applyStimulus();
  endtask

  // Load the flag register through an always-executed instruction.
  task automatic loadFlags(input logic [3:0] f);
    fetchDecode(4'hE);
    ALUFlags = f; FlagW = 2'b11;
    applyStimulus();
    idleInputs();
  endtask

  initial begin
    reset = 0; Cond = 4'h0;
    idleInputs();
    modelReset();
    #1;
    checkOutput("reset");
    applyStimulus();
    applyStimulus();
    reset = 1;
    applyStimulus();
    checkOutput("postReset");

    fetchDecode(4'hE);
    RegW = 1; #1;
    checkOutput("alRegW");
    chk("alRegWrite", 32'(RegWrite), 32'd1);
    chk("alExec", 32'(exec_count), 32'd1);

    loadFlags(4'b0100);
    fetchDecode(4'h1);
    MemW = 1; #1;
    checkOutput("neMemW");
    chk("neMemWrite", 32'(MemWrite), 32'd0);
    chk("neSquash", 32'(squash_count), 32'd1);
    Branch = 1; NextPC = 0; #1;
    checkOutput("branchSquashed");
    chk("branchPC0", 32'(PCWrite), 32'd0);
    NextPC = 1; #1;
    checkOutput("nextPcUngated");
    chk("branchPC1", 32'(PCWrite), 32'd1);
    fetchDecode(4'h0);
    checkOutput("eqPass");
    chk("eqCondEx", 32'(CondExQ), 32'd1);

    ALUFlags = 4'b1001; FlagW = 2'b10;
    applyStimulus();
    checkOutput("flagWnz");
    chk("flagsHalf", 32'(Flags), 32'b1000);
    fetchDecode(4'hF);
    ALUFlags = 4'b0111; FlagW = 2'b11;
    applyStimulus();
    checkOutput("flagWsquashed");
    chk("flagsHeld", 32'(Flags), 32'b1000);

    for (int f = 0; f < 16; f++) begin
      loadFlags(4'(f));
      for (int c = 0; c < 16; c++) begin
        fetchDecode(4'(c));
        checkOutput($sformatf("sweep_f%0h_c%0h", f, c));
      end
    end

    for (int i = 0; i < 400; i++) begin
      Cond = 4'($urandom); ALUFlags = 4'($urandom); FlagW = 2'($urandom);
      IRWrite = 1'($urandom); RegW = 1'($urandom); MemW = 1'($urandom);
      NextPC = 1'($urandom); Branch = 1'($urandom);
      cnt_clr = ($urandom_range(0, 15) == 0);
      #1;
      checkOutput("randComb");
      applyStimulus();
      checkOutput("randSeq");
    end

    idleInputs();
    cnt_clr = 1;
    applyStimulus();
    cnt_clr = 0;
    checkOutput("clr0");
    for (int i = 0; i < 17; i++) fetchDecode(4'hE);
    checkOutput("sat");
    chk("execSat", 32'(exec_count), 32'(CMAX));

    idleInputs();
    IRWrite = 1;
    applyStimulus();
    idleInputs();
    Cond = 4'hE; cnt_clr = 1;
    applyStimulus();
    cnt_clr = 0;
    checkOutput("clrInDecode");
    chk("execCleared", 32'(exec_count), 32'd0);

    RegW = 1; MemW = 1; Branch = 1; NextPC = 1;
    #2;
    reset = 0;
    #1;
    modelReset();
    checkOutput("midReset");
    chk("midResetPC", 32'(PCWrite), 32'd1);
    chk("midResetReg", 32'(RegWrite), 32'd0);
    applyStimulus();
    checkOutput("resetHeld");
    reset = 1;
    fetchDecode(4'hE);
    checkOutput("reEval");
    chk("reEvalExec", 32'(exec_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
